// File: rtl/cnt_timer_ctrl.sv
// cnt_timer_ctrl: sequences an external loadable up-counter as a one-shot or periodic timer with prescaler.
// load/enab are decoded only from registered state and cnt_out, so start/stop/config never reach them.
module cnt_timer_ctrl #(
    parameter int WIDTH      = 5,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode_periodic,
    input  logic [WIDTH-1:0]      start_val,
    input  logic [WIDTH-1:0]      period,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  irq_clr,
    input  logic [WIDTH-1:0]      cnt_out,
    output logic                  load,
    output logic                  enab,
    output logic [WIDTH-1:0]      cnt_in,
    output logic                  busy,
    output logic                  tick_done,
    output logic                  irq
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                state_q;
    logic [WIDTH-1:0]      start_s_q, period_s_q;
    logic [PRESCALE_W-1:0] pre_s_q, pre_cnt_q, pre_cnt_d;
    logic                  mode_s_q, busy_q, tick_done_q, irq_q;
    logic                  tick, expire;

    always_comb begin
        tick      = (state_q == RUN) && (pre_cnt_q == pre_s_q);
        expire    = tick && (cnt_out == period_s_q);
        pre_cnt_d = (state_q != RUN || tick) ? '0 : pre_cnt_q + 1'b1;
    end

    assign load      = (state_q == LOAD) || (expire && mode_s_q);
    assign enab      = tick && !expire;
    assign cnt_in    = start_s_q;
    assign busy      = busy_q;
    assign tick_done = tick_done_q;
    assign irq       = irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            start_s_q   <= '0;
            period_s_q  <= '0;
            pre_s_q     <= '0;
            mode_s_q    <= 1'b0;
            pre_cnt_q   <= '0;
            busy_q      <= 1'b0;
            tick_done_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            // an abort in the expiry cycle suppresses the expiry report
            tick_done_q <= expire && !stop;
            irq_q       <= (expire && !stop) || (irq_q && !irq_clr);
            pre_cnt_q   <= pre_cnt_d;
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        start_s_q  <= start_val;
                        period_s_q <= period;
                        pre_s_q    <= prescale;
                        mode_s_q   <= mode_periodic;
                        state_q    <= LOAD;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q <= stop ? IDLE : RUN;
                    busy_q  <= !stop;
                end
                RUN: begin
                    if (stop || (expire && !mode_s_q)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cnt_timer_ctrl.sv
// tb_cnt_timer_ctrl: drives cnt_timer_ctrl against a behavioural up-counter and
// compares every cycle with expectations derived from the timer's expiry formulas.
module tb_cnt_timer_ctrl;
    localparam int W = 5;
    localparam int MASK = (1 << W) - 1;

    typedef struct packed {
        logic       load;
        logic       enab;
        logic       busy;
        logic       td;
        logic       irq;
        logic [W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, stop, mode_periodic, irq_clr;
    logic [W-1:0] start_val, period, cnt_out, cnt_in;
    logic [3:0] prescale;
    logic load, enab, busy, tick_done, irq;

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];
    exp_t obs, e;

    always #5 clk = ~clk;

    cnt_timer_ctrl #(.WIDTH(W), .PRESCALE_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .mode_periodic(mode_periodic), .start_val(start_val), .period(period),
        .prescale(prescale), .irq_clr(irq_clr), .cnt_out(cnt_out),
        .load(load), .enab(enab), .cnt_in(cnt_in), .busy(busy),
        .tick_done(tick_done), .irq(irq)
    );

    // the loadable up-counter the controller sits in front of
    always @(posedge clk) begin
        if (rst) cnt_out <= '0;
        else if (load) cnt_out <= cnt_in;
        else if (enab) cnt_out <= cnt_out + 1'b1;
    end

    // expected outputs in cycle c after start was sampled in cycle 0
    function automatic exp_t exp_at(int c, int sv, int per, int pre, bit mode,
                                    bit irq1, int cnt0, int stop_c);
        exp_t r;
        int n, l, cc, k, ph, rr;
        bit tk, ex, idle;
        n  = ((per - sv) & MASK) + 1;
        l  = n * (pre + 1);
        idle = (stop_c > 0) && (c > stop_c);
        cc = idle ? stop_c : c;
        if (cc == 1) begin
            r = '{1'b1, 1'b0, 1'b1, 1'b0, irq1, W'(cnt0)};
        end else if (!mode && cc >= l + 2) begin
            r = '{1'b0, 1'b0, 1'b0, (cc == l + 2), 1'b1, W'(per)};
        end else begin
            rr = (cc - 2) % l;
            k  = rr / (pre + 1);
            ph = rr % (pre + 1);
            tk = (ph == pre);
            ex = tk && (k == n - 1);
            r.load = ex && mode;
            r.enab = tk && !ex;
            r.busy = 1'b1;
            r.td   = (cc >= 3) && ((cc - 3) % l == l - 1);
            r.irq  = irq1 || (cc >= l + 2);
            r.cnt  = W'((sv + k) & MASK);
        end
        if (idle) begin
            r.load = 1'b0;
            r.enab = 1'b0;
            r.busy = 1'b0;
            r.td   = 1'b0;
        end
        return r;
    endfunction

    task automatic launch(int sv, int per, int pre, bit mode, bit clr, bit irq1,
                          int cnt0, int stop_c, int m);
        start_val = W'(sv);
        period = W'(per);
        prescale = 4'(pre);
        mode_periodic = mode;
        irq_clr = clr;
        start = 1'b1;
        for (int c = 1; c <= m; c++) exp_q.push_back(exp_at(c, sv, per, pre, mode, irq1, cnt0, stop_c));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        obs = {load, enab, busy, tick_done, irq, cnt_out};
        tests++;
        if (obs !== exp_t'(0)) begin
            fails++;
            $display("FAIL reset outputs got %b want %b", obs, exp_t'(0));
        end
        tests++;
        if (cnt_in !== '0) begin
            fails++;
            $display("FAIL reset cnt_in got %0d want 0", cnt_in);
        end
        rst = 1'b0;
    endtask

    task automatic test_oneshot(bit irq1);
        launch(3, 5, 0, 1'b0, 1'b0, irq1, 0, 0, 8);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            obs = {load, enab, busy, tick_done, irq, cnt_out};
            e = exp_q.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL oneshot c%0d got %b want %b", c, obs, e);
            end
            if (c == 1) begin
                tests++;
                if (cnt_in !== 5'd3) begin
                    fails++;
                    $display("FAIL oneshot cnt_in got %0d want 3", cnt_in);
                end
                start = 1'b0;
            end
            if (c == 2) begin
                start_val = W'($urandom);
                period = W'($urandom);
                prescale = 4'($urandom);
                mode_periodic = 1'b1;
            end
        end
    endtask

    task automatic test_periodic();
        launch(0, 2, 1, 1'b1, 1'b1, 1'b0, 5, 16, 19);
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            obs = {load, enab, busy, tick_done, irq, cnt_out};
            e = exp_q.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL periodic c%0d got %b want %b", c, obs, e);
            end
            if (c == 1) begin
                start = 1'b0;
                irq_clr = 1'b0;
            end
            stop = (c == 16);
        end
    endtask

    task automatic test_stop_and_busy_start();
        launch(0, 20, 1, 1'b0, 1'b1, 1'b0, 1, 6, 10);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            obs = {load, enab, busy, tick_done, irq, cnt_out};
            e = exp_q.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL stop c%0d got %b want %b", c, obs, e);
            end
            irq_clr = 1'b0;
            start = (c == 3 || c == 4);
            start_val = 5'd9;
            stop = (c == 6);
        end
    endtask

    task automatic test_wrap();
        launch(30, 1, 0, 1'b0, 1'b1, 1'b0, 2, 0, 8);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            obs = {load, enab, busy, tick_done, irq, cnt_out};
            e = exp_q.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL wrap c%0d got %b want %b", c, obs, e);
            end
            start = 1'b0;
            irq_clr = 1'b0;
        end
    endtask

    task automatic test_reset_mid_run();
        launch(3, 5, 3, 1'b1, 1'b0, 1'b1, 1, 0, 4);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            obs = {load, enab, busy, tick_done, irq, cnt_out};
            e = exp_q.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL rstrun c%0d got %b want %b", c, obs, e);
            end
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        obs = {load, enab, busy, tick_done, irq, cnt_out};
        tests++;
        if (obs !== exp_t'(0) || cnt_in !== '0) begin
            fails++;
            $display("FAIL rstrun after-reset got %b cnt_in %0d want %b cnt_in 0", obs, cnt_in, exp_t'(0));
        end
        rst = 1'b0;
    endtask

    task automatic test_irq_clr();
        launch(7, 8, 0, 1'b0, 1'b1, 1'b0, 5, 0, 0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                tests++;
                if (irq !== 1'b0) begin
                    fails++;
                    $display("FAIL irqclr c1 irq got %b want 0", irq);
                end
            end
            if (c == 3) begin
                tests++;
                if (busy !== 1'b1 || irq !== 1'b0) begin
                    fails++;
                    $display("FAIL irqclr c3 busy/irq got %b%b want 10", busy, irq);
                end
            end
            if (c == 4) begin
                tests++;
                if (tick_done !== 1'b1 || irq !== 1'b1 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL irqclr c4 td/irq/busy got %b%b%b want 110", tick_done, irq, busy);
                end
            end
            if (c == 5) begin
                tests++;
                if (tick_done !== 1'b0 || irq !== 1'b0) begin
                    fails++;
                    $display("FAIL irqclr c5 td/irq got %b%b want 00", tick_done, irq);
                end
            end
            start = 1'b0;
            irq_clr = (c == 3 || c == 4);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        irq_clr = 1'b0;
        mode_periodic = 1'b0;
        start_val = '0;
        period = '0;
        prescale = '0;
        test_reset();
        test_oneshot(1'b0);
        test_periodic();
        test_stop_and_busy_start();
        test_wrap();
        test_reset_mid_run();
        test_oneshot(1'b0);
        test_irq_clr();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
